// File: rtl/avalon_led_pkg.sv
// Shared constants for the LED PWM/blink slave: register map, CTRL bit
// positions and reset values.
package avalon_led_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_DUTY     = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_BLINK    = 2'd3;

    localparam int CTRL_ENABLE_BIT      = 0;
    localparam int CTRL_BLINK_EN_BIT    = 1;
    localparam int BLINK_PHASE_RD_BIT   = 31;

    typedef struct packed {
        logic blink_en;
        logic enable;
    } ctrl_t;

    localparam ctrl_t       CTRL_RST       = '{blink_en: 1'b0, enable: 1'b0};
    localparam int          PRESCALE_RST   = 0;
    localparam logic [15:0] BLINK_HALF_RST = 16'h0000;

    // Pull the CTRL fields out of a bus word; all other bits are ignored.
    function automatic ctrl_t ctrl_from_wdata(input logic [31:0] wdata);
        ctrl_t c;
        c.enable   = wdata[CTRL_ENABLE_BIT];
        c.blink_en = wdata[CTRL_BLINK_EN_BIT];
        return c;
    endfunction

endpackage

// File: rtl/avalon_led_pwm_if.sv
// Avalon-MM register port of the LED PWM slave (no wait states).
interface avalon_led_pwm_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pwm_timebase.sv
// Prescaler + PWM period counter. clear_i restarts both counters and
// takes priority over counting; period_end_o is the registered copy of
// the internal last-tick strobe.
module led_pwm_timebase #(
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [PWM_BITS-1:0]   pwm_cnt_o,
    output logic                  period_end_int_o,
    output logic                  period_end_o
);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                  period_end_q, period_end_d;
    logic                  tick;

    // Next-state for prescaler, PWM counter and period strobe.
    always_comb begin
        tick             = (pre_cnt_q == prescale_i);
        period_end_int_o = tick && (pwm_cnt_q == '1) && !clear_i;
        pre_cnt_d        = pre_cnt_q;
        pwm_cnt_d        = pwm_cnt_q;
        period_end_d     = period_end_int_o;
        if (clear_i) begin
            pre_cnt_d = '0;
            pwm_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
        end
    end

    // Counter and strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q    <= '0;
            pwm_cnt_q    <= '0;
            period_end_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            period_end_q <= period_end_d;
        end
    end

    assign pwm_cnt_o    = pwm_cnt_q;
    assign period_end_o = period_end_q;

endmodule

// File: rtl/avalon_led_pwm.sv
// LED brightness/blink stage behind the LED PIO. Holds the register file,
// blink phase logic and the registered LED drive; timing comes from
// led_pwm_timebase. Optional build macro: LED_GAMMA_EN (squared duty curve).
module avalon_led_pwm
    import avalon_led_pkg::*;
#(
    parameter int NUM_LEDS   = 18,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_led_pwm_if.slave     bus,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_end
);

    ctrl_t                 ctrl_q, ctrl_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [15:0]           blink_half_q, blink_half_d;
    logic [15:0]           blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_LEDS-1:0]   led_out_q, led_out_d;
    logic [PWM_BITS-1:0]   duty_eff;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  period_end_int;
    logic                  wr;
    logic                  tb_clear;
    logic                  blink_clear;
    logic                  pwm_on;
    logic                  unused_wdata;

    assign wr           = bus.chipselect && !bus.write_n;
    assign tb_clear     = wr && (bus.address == ADDR_PRESCALE);
    assign blink_clear  = wr && (bus.address == ADDR_CTRL) && !bus.writedata[CTRL_BLINK_EN_BIT];
    assign unused_wdata = ^bus.writedata;

    led_pwm_timebase #(
        .PWM_BITS   (PWM_BITS),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk              (clk),
        .reset_n          (reset_n),
        .clear_i          (tb_clear),
        .prescale_i       (prescale_q),
        .pwm_cnt_o        (pwm_cnt),
        .period_end_int_o (period_end_int),
        .period_end_o     (period_end)
    );

`ifdef LED_GAMMA_EN
    logic [PWM_BITS-1:0] duty_eff_q, duty_eff_d;

    // Squared brightness curve, full scale pinned to fully on.
    always_comb begin
        duty_eff_d = PWM_BITS'(({{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q}) >> PWM_BITS);
        if (duty_q == '1) begin
            duty_eff_d = '1;
        end
    end

    // Gamma-corrected duty register, one cycle behind DUTY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_eff_q <= '1;
        end else begin
            duty_eff_q <= duty_eff_d;
        end
    end

    assign duty_eff = duty_eff_q;
`else
    assign duty_eff = duty_q;
`endif

    // Register-file write decode.
    always_comb begin
        ctrl_d       = ctrl_q;
        duty_d       = duty_q;
        prescale_d   = prescale_q;
        blink_half_d = blink_half_q;
        if (wr) begin
            case (bus.address)
                ADDR_CTRL:     ctrl_d       = ctrl_from_wdata(bus.writedata);
                ADDR_DUTY:     duty_d       = bus.writedata[PWM_BITS-1:0];
                ADDR_PRESCALE: prescale_d   = bus.writedata[PRESCALE_W-1:0];
                default:       blink_half_d = bus.writedata[15:0];
            endcase
        end
    end

    // Blink half-period counter; a CTRL write turning blink off resets it.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (blink_clear) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (period_end_int) begin
            if (blink_cnt_q == blink_half_q) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    // LED drive: pass-through when disabled, otherwise PWM and blink gated.
    always_comb begin
        pwm_on    = (duty_eff == '1) || (pwm_cnt < duty_eff);
        led_out_d = led_in;
        if (ctrl_q.enable) begin
            led_out_d = led_in & {NUM_LEDS{pwm_on && (!ctrl_q.blink_en || !blink_phase_q)}};
        end
    end

    // Combinational readback, unused bits zero.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                bus.readdata[CTRL_ENABLE_BIT]   = ctrl_q.enable;
                bus.readdata[CTRL_BLINK_EN_BIT] = ctrl_q.blink_en;
            end
            ADDR_DUTY:     bus.readdata[PWM_BITS-1:0]   = duty_q;
            ADDR_PRESCALE: bus.readdata[PRESCALE_W-1:0] = prescale_q;
            default: begin
                bus.readdata[15:0]               = blink_half_q;
                bus.readdata[BLINK_PHASE_RD_BIT] = blink_phase_q;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= CTRL_RST;
            duty_q        <= '1;
            prescale_q    <= PRESCALE_W'(PRESCALE_RST);
            blink_half_q  <= BLINK_HALF_RST;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            led_out_q     <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            duty_q        <= duty_d;
            prescale_q    <= prescale_d;
            blink_half_q  <= blink_half_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_out_q     <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule
